// File: rtl/quad_encoder_pkg.sv
// Shared encoder definitions: quadrature state codes, direction values, transition classifier.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package quad_encoder_pkg;

  // Quadrature states written as {A,B}
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_INC     = 2'd1,
    TR_DEC     = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  // Classify a move between two filtered {A,B} samples.
  // A leads B when counting up: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic trans_t classify_step(input logic [1:0] prev, input logic [1:0] curr);
    trans_t t;
    t = TR_NONE;
    if (prev != curr) begin
      if ((prev[1] != curr[1]) && (prev[0] != curr[0])) begin
        t = TR_ILLEGAL;
      end else begin
        case (prev)
          Q00:     t = (curr == Q10) ? TR_INC : TR_DEC;
          Q10:     t = (curr == Q11) ? TR_INC : TR_DEC;
          Q11:     t = (curr == Q01) ? TR_INC : TR_DEC;
          Q01:     t = (curr == Q00) ? TR_INC : TR_DEC;
          default: t = TR_NONE;
        endcase
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/quad_encoder_counter_debounce.sv
// One-channel pin debouncer: filtered follows raw once raw has differed for DEBOUNCE_CYCLES edges.
// Latency: DEBOUNCE_CYCLES edges from a held raw change to filtered.
// Backpressure: none; raw is sampled every cycle.
module quad_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  // Count of the last edge before filtered flips; a counter reaching this
  // value on the next increment would equal DEBOUNCE_CYCLES.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] cnt;

  // Run-length counter of consecutive disagreeing samples; any agreeing sample restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      filtered <= raw;
    end else if (raw == filtered) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      filtered <= raw;
      cnt      <= '0;
    end else begin
      cnt <= cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: debounce A/B, x4 decode, wrapping count, dir, step strobe, sticky err.
// Latency: DEBOUNCE_CYCLES+1 edges from a held raw pin change to count/step update.
// Backpressure: none; every decoded step is counted unless clear/load claims the same edge.
module quad_encoder_counter
  import quad_encoder_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic       filt_a;
  logic       filt_b;
  logic [1:0] prev;
  logic [1:0] curr;
  trans_t     trans;

  quad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db_a (
    .clk     (clk),
    .rst     (rst),
    .raw     (enc_a),
    .filtered(filt_a)
  );

  quad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db_b (
    .clk     (clk),
    .rst     (rst),
    .raw     (enc_b),
    .filtered(filt_b)
  );

  // Classify the move between last cycle's filtered state and the current one.
  always_comb begin
    curr  = {filt_a, filt_b};
    trans = classify_step(prev, curr);
  end

  // Count/dir/err/step registers. prev tracks filtered every cycle, including
  // during clear/load, so a transition claimed by clear/load is consumed rather
  // than replayed on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dir   <= DIR_DOWN;
      step  <= 1'b0;
      err   <= 1'b0;
      // Seed from the live pins so the first edge after reset is never a transition.
      prev  <= {enc_a, enc_b};
    end else begin
      prev <= curr;
      step <= 1'b0;
      if (clear) begin
        count <= '0;
        dir   <= DIR_DOWN;
        err   <= 1'b0;
      end else if (load) begin
        count <= load_val;
      end else begin
        case (trans)
          TR_INC: begin
            count <= count + CNT_W'(1);
            dir   <= DIR_UP;
            step  <= 1'b1;
          end
          TR_DEC: begin
            count <= count - CNT_W'(1);
            dir   <= DIR_DOWN;
            step  <= 1'b1;
          end
          TR_ILLEGAL: begin
            err <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Self-checking bench for quad_encoder_counter: directed scenarios plus randomized traffic vs a model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_quad_encoder_counter;

  localparam int CNT_W = 8;
  localparam int NDB   = 4;

  logic             clk;
  logic             rst;
  logic             enc_a;
  logic             enc_b;
  logic             clear;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  int checks;
  int failures;

  // Reference model state (behavioural, integer position)
  int   m_count;
  logic m_dir;
  logic m_step;
  logic m_err;
  logic m_fa;
  logic m_fb;
  logic [1:0] m_prev;
  logic hist_a[$];
  logic hist_b[$];
  int   gray_pos[4];

  quad_encoder_counter #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(NDB),
    .DB_W           (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // True when the last NDB raw samples all disagree with the filtered value.
  function automatic logic held_differs(input logic h[$], input logic f);
    if (h.size() < NDB) return 1'b0;
    foreach (h[i]) if (h[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one rising edge using the inputs presented at that edge.
  task automatic model_edge();
    int d;
    logic [1:0] cur;
    if (rst) begin
      m_count = 0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
      m_fa = enc_a; m_fb = enc_b; m_prev = {enc_a, enc_b};
      hist_a.delete(); hist_b.delete();
    end else begin
      cur = {m_fa, m_fb};
      // position along the cycle 00,10,11,01: +1 is up, +3 is down, +2 illegal
      d = (gray_pos[cur] - gray_pos[m_prev] + 4) % 4;
      m_step = 1'b0;
      if (clear) begin
        m_count = 0; m_dir = 1'b0; m_err = 1'b0;
      end else if (load) begin
        m_count = int'(load_val);
      end else if (d == 1) begin
        m_count = (m_count + 1) % 256; m_dir = 1'b1; m_step = 1'b1;
      end else if (d == 3) begin
        m_count = (m_count + 255) % 256; m_dir = 1'b0; m_step = 1'b1;
      end else if (d == 2) begin
        m_err = 1'b1;
      end
      m_prev = cur;
      hist_a.push_back(enc_a); if (hist_a.size() > NDB) void'(hist_a.pop_front());
      hist_b.push_back(enc_b); if (hist_b.size() > NDB) void'(hist_b.pop_front());
      if (held_differs(hist_a, m_fa)) m_fa = enc_a;
      if (held_differs(hist_b, m_fb)) m_fb = enc_b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    {enc_a, enc_b} = ab;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b11);
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b exp=0", dir); end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (step !== 1'b0 || count !== 8'h00) begin
        failures++; $display("FAIL reset_quiet cyc=%0d step=%b count=%h exp step=0 count=00", k, step, count);
      end
    end
  endtask

  task automatic test_increment();
    logic [1:0] seq[4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset(2'b00);
    for (int i = 0; i < 4; i++) begin
      {enc_a, enc_b} = seq[i];
      for (int k = 1; k <= 6; k++) begin
        tick();
        checks++; if (step !== (k == 5)) begin
          failures++; $display("FAIL inc_step phase=%0d edge=%0d got=%b exp=%b", i, k, step, (k == 5));
        end
      end
      checks++; if (count !== 8'(i + 1)) begin
        failures++; $display("FAIL inc_count phase=%0d got=%h exp=%h", i, count, 8'(i + 1));
      end
    end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL inc_dir got=%b exp=1", dir); end
  endtask

  task automatic test_glitch();
    enc_a = 1'b1;
    tick(); tick(); tick();
    enc_a = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL glitch_step cyc=%0d got=%b exp=0", k, step); end
    end
    checks++; if (count !== 8'h04) begin failures++; $display("FAIL glitch_count got=%h exp=04", count); end
    enc_a = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    checks++; if (count !== 8'h05 || step !== 1'b1) begin
      failures++; $display("FAIL held4_count got=%h step=%b exp=05 step=1", count, step);
    end
    enc_a = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (count !== 8'h04 || dir !== 1'b0) begin
      failures++; $display("FAIL held4_back got=%h dir=%b exp=04 dir=0", count, dir);
    end
  endtask

  task automatic test_wrap();
    load_val = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (count !== 8'hFF || step !== 1'b0) begin
      failures++; $display("FAIL load_ff got=%h step=%b exp=ff step=0", count, step);
    end
    {enc_a, enc_b} = 2'b10;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL wrap_up got=%h exp=00", count); end
    {enc_a, enc_b} = 2'b00;
    for (int k = 0; k < 6; k++) tick();
    {enc_a, enc_b} = 2'b01;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (count !== 8'hFE || dir !== 1'b0) begin
      failures++; $display("FAIL wrap_down got=%h dir=%b exp=fe dir=0", count, dir);
    end
  endtask

  task automatic test_illegal();
    do_reset(2'b00);
    load_val = 8'h30; load = 1'b1;
    tick();
    load = 1'b0;
    {enc_a, enc_b} = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL illegal_step cyc=%0d got=%b exp=0", k, step); end
    end
    checks++; if (err !== 1'b1 || count !== 8'h30) begin
      failures++; $display("FAIL illegal got err=%b count=%h exp err=1 count=30", err, count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (err !== 1'b0 || count !== 8'h00 || dir !== 1'b0) begin
      failures++; $display("FAIL clear got err=%b count=%h dir=%b exp 0/00/0", err, count, dir);
    end
  endtask

  task automatic test_simultaneous();
    // filtered is 11; 11 -> 01 is an increment that decodes on the 5th edge
    {enc_a, enc_b} = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    load_val = 8'h55; load = 1'b1;
    tick();
    load = 1'b0;
    checks++; if (count !== 8'h55 || step !== 1'b0) begin
      failures++; $display("FAIL load_vs_step got=%h step=%b exp=55 step=0", count, step);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (count !== 8'h55 || dir !== 1'b0) begin
      failures++; $display("FAIL consumed got=%h dir=%b exp=55 dir=0", count, dir);
    end
    load_val = 8'hAA; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    checks++; if (count !== 8'h00) begin failures++; $display("FAIL clear_over_load got=%h exp=00", count); end
  endtask

  task automatic test_random();
    int hold;
    do_reset(2'($urandom));
    for (int seg = 0; seg < 90; seg++) begin
      {enc_a, enc_b} = 2'($urandom);
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        clear    = ($urandom_range(0, 15) == 0);
        load     = ($urandom_range(0, 15) == 0);
        load_val = 8'($urandom);
        rst      = ($urandom_range(0, 99) == 0);
        tick();
        clear = 1'b0; load = 1'b0; rst = 1'b0;
        checks++; if (count !== 8'(m_count) || dir !== m_dir || step !== m_step || err !== m_err) begin
          failures++;
          $display("FAIL random seg=%0d got count=%h dir=%b step=%b err=%b exp count=%h dir=%b step=%b err=%b",
                   seg, count, dir, step, err, 8'(m_count), m_dir, m_step, m_err);
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    gray_pos = '{0, 3, 1, 2};
    rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0;
    m_count = 0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
    m_fa = 1'b0; m_fb = 1'b0; m_prev = 2'b00;
    test_reset();
    test_increment();
    test_glitch();
    test_wrap();
    test_illegal();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
